// File: rtl/shader_dispatch_sched.sv
// Shader thread dispatch scheduler: round-robin raster requesters
// feed coordinates to the lowest free shader thread.
module shader_dispatch_sched #(
    parameter int NoR = 2,
    parameter int NoS = 4,
    parameter int DW  = 24
) (
    input  logic                       core_clock_i,
    input  logic                       core_reset_i,
    input  logic                       enable_i,
    input  logic [NoR-1:0]             req_valid_i,
    input  logic [DW*NoR-1:0]          req_data_i,
    output logic [NoR-1:0]             req_ready_o,
    input  logic [NoS-1:0]             thrend_i,
    output logic [DW-1:0]              data_o,
    output logic [NoS-1:0]             write_coords_o,
    output logic [NoS-1:0]             reset_o,
    output logic [$clog2(NoS+1)-1:0]   active_count_o,
    output logic                       idle_o
);

    localparam int CW = $clog2(NoS + 1);
    localparam int PW = (NoR > 1) ? $clog2(NoR) : 1;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2
    } thr_state_e;

    thr_state_e     state_q [NoS];
    thr_state_e     state_d [NoS];
    logic [PW-1:0]  rr_ptr;
    logic [PW-1:0]  gnt;
    logic [PW-1:0]  hi_idx;
    logic [PW-1:0]  lo_idx;
    logic           hi_found;
    logic [DW-1:0]  gnt_data;
    logic [NoS-1:0] free_oh;
    logic           any_free;
    logic           all_free;
    logic           dispatch;
    logic [CW-1:0]  cnt_d;

    // Round-robin pick: lowest valid index at or above rr_ptr, else wrap
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NoR - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                lo_idx = PW'(i);
                if (PW'(i) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = PW'(i);
                end
            end
        end
        gnt      = hi_found ? hi_idx : lo_idx;
        gnt_data = '0;
        for (int i = 0; i < NoR; i++) begin
            if (gnt == PW'(i)) begin
                gnt_data = req_data_i[DW*i +: DW];
            end
        end
    end

    // Lowest-index FREE thread, plus the all-free flag for idle
    always_comb begin
        free_oh  = '0;
        any_free = 1'b0;
        all_free = 1'b1;
        for (int i = 0; i < NoS; i++) begin
            if (state_q[i] == FREE) begin
                if (!any_free) begin
                    free_oh[i] = 1'b1;
                end
                any_free = 1'b1;
            end else begin
                all_free = 1'b0;
            end
        end
    end

    assign dispatch = enable_i & any_free & (|req_valid_i) & ~core_reset_i;

    // Pop strobe to the granted requester and launch strobes to threads
    always_comb begin
        req_ready_o    = '0;
        write_coords_o = '0;
        for (int i = 0; i < NoR; i++) begin
            req_ready_o[i] = dispatch && (gnt == PW'(i));
        end
        for (int i = 0; i < NoS; i++) begin
            write_coords_o[i] = (state_q[i] == LAUNCH) && !core_reset_i;
        end
    end

    assign reset_o = write_coords_o;
    assign idle_o  = all_free && (req_valid_i == '0);

    // Per-thread next state and the resulting occupancy count
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NoS; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                FREE:    if (dispatch && free_oh[i]) state_d[i] = LAUNCH;
                LAUNCH:  state_d[i] = BUSY;
                BUSY:    if (thrend_i[i]) state_d[i] = FREE;
                default: state_d[i] = FREE;
            endcase
            if (state_d[i] != FREE) begin
                cnt_d = cnt_d + CW'(1);
            end
        end
    end

    // Thread state registers
    always_ff @(posedge core_clock_i) begin
        if (core_reset_i) begin
            for (int i = 0; i < NoS; i++) begin
                state_q[i] <= FREE;
            end
        end else begin
            for (int i = 0; i < NoS; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // Round-robin pointer, dispatched coordinates and occupancy count
    always_ff @(posedge core_clock_i) begin
        if (core_reset_i) begin
            rr_ptr         <= '0;
            data_o         <= '0;
            active_count_o <= '0;
        end else begin
            active_count_o <= cnt_d;
            if (dispatch) begin
                data_o <= gnt_data;
                rr_ptr <= (gnt == PW'(NoR - 1)) ? '0 : gnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shader_dispatch_sched.sv
// Scoreboard bench for shader_dispatch_sched: stimulus queues expected
// launches, a negedge monitor pops and compares them.
module tb_shader_dispatch_sched;

    typedef struct packed {
        logic [23:0] data;
        logic [3:0]  thr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  valid;
    logic [23:0] d0;
    logic [23:0] d1;
    logic [1:0]  ready;
    logic [3:0]  thrend;
    logic [23:0] data;
    logic [3:0]  wr;
    logic [3:0]  rso;
    logic [2:0]  cnt;
    logic        idle;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   rdy_tab[4] = '{1, 2, 1, 2};

    shader_dispatch_sched #(.NoR(2), .NoS(4), .DW(24)) dut (
        .core_clock_i   (clk),
        .core_reset_i   (rst),
        .enable_i       (en),
        .req_valid_i    (valid),
        .req_data_i     ({d1, d0}),
        .req_ready_o    (ready),
        .thrend_i       (thrend),
        .data_o         (data),
        .write_coords_o (wr),
        .reset_o        (rso),
        .active_count_o (cnt),
        .idle_o         (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every launch strobe must match the oldest queued dispatch
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (wr != 4'd0) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_launch: got wr=%0h expected none", wr);
                end else begin
                    e = q.pop_front();
                    chk("launch_thread", 32'(wr), 32'(e.thr));
                    chk("launch_reset_o", 32'(rso), 32'(e.thr));
                    chk("launch_data", 32'(data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b1; valid = 2'b11;
        d0 = 24'h0; d1 = 24'h0; thrend = 4'h0;
        step();
        @(negedge clk);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_write", 32'(wr), 0);
        step();
        rst = 1'b0; valid = 2'b00;
        @(negedge clk);
        chk("rst_data", 32'(data), 0);
        chk("rst_count", 32'(cnt), 0);
        chk("rst_idle", 32'(idle), 1);
        chk("rst_ready_idle", 32'(ready), 0);

        // single dispatch from requester 0
        step();
        valid = 2'b01; d0 = 24'h000102;
        @(negedge clk);
        chk("first_ready", 32'(ready), 1);
        q.push_back('{data: 24'h000102, thr: 4'b0001});
        step();
        valid = 2'b00;
        @(negedge clk);
        chk("first_count", 32'(cnt), 1);

        // reset while thread 0 busy: abandon, no strobes
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("busy_rst_write", 32'(wr), 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("busy_rst_count", 32'(cnt), 0);

        // both requesters valid: alternate grants, fill threads 0..3
        for (int k = 0; k < 4; k++) begin
            step();
            valid = 2'b11;
            d0 = 24'(32'hA00000 + k);
            d1 = 24'(32'hB00000 + k);
            @(negedge clk);
            chk("rr_ready", 32'(ready), 32'(rdy_tab[k]));
            q.push_back('{data: (k % 2 == 1) ? d1 : d0, thr: 4'(1 << k)});
        end
        step();
        @(negedge clk);
        chk("full_ready", 32'(ready), 0);
        chk("full_count", 32'(cnt), 4);

        // free thread 2: not reusable in the freeing cycle
        step();
        valid = 2'b01; d0 = 24'hC00001; thrend = 4'b0100;
        @(negedge clk);
        chk("free_same_cycle_ready", 32'(ready), 0);
        chk("free_count4", 32'(cnt), 4);
        chk("data_hold", 32'(data), 32'h00B00003);
        step();
        thrend = 4'b0000;
        @(negedge clk);
        chk("free_count3", 32'(cnt), 3);
        chk("refill_ready", 32'(ready), 1);
        q.push_back('{data: 24'hC00001, thr: 4'b0100});

        // thrend during LAUNCH is ignored
        step();
        valid = 2'b00; thrend = 4'b0100;
        @(negedge clk);
        chk("refill_count4", 32'(cnt), 4);
        step();
        thrend = 4'b0000; valid = 2'b01;
        @(negedge clk);
        chk("launch_end_count", 32'(cnt), 4);
        chk("launch_end_ready", 32'(ready), 0);

        // release all threads
        step();
        thrend = 4'b1111; valid = 2'b00;
        @(negedge clk);
        chk("release_count", 32'(cnt), 4);

        // enable low blocks grants
        step();
        thrend = 4'b0000; en = 1'b0; valid = 2'b11;
        d0 = 24'hD00000; d1 = 24'hD00001;
        @(negedge clk);
        chk("dis_ready0", 32'(ready), 0);
        chk("dis_count", 32'(cnt), 0);
        chk("dis_idle", 32'(idle), 0);
        step();
        @(negedge clk);
        chk("dis_ready1", 32'(ready), 0);
        step();
        en = 1'b1;
        @(negedge clk);
        chk("en_ready", 32'(ready), 2);
        q.push_back('{data: 24'hD00001, thr: 4'b0001});

        // reset in a dispatch cycle with thread 0 in LAUNCH
        step();
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        chk("rst_disp_ready", 32'(ready), 0);
        chk("rst_disp_write", 32'(wr), 0);
        chk("rst_disp_reset_o", 32'(rso), 0);
        chk("rst_disp_data", 32'(data), 32'h00D00001);
        step();
        rst = 1'b0; valid = 2'b00;
        @(negedge clk);
        chk("post_rst_data", 32'(data), 0);
        chk("post_rst_count", 32'(cnt), 0);
        chk("post_rst_idle", 32'(idle), 1);
        chk("post_rst_ready", 32'(ready), 0);
        chk("post_rst_write", 32'(wr), 0);
        step();
        @(negedge clk);
        chk("post_rst_write2", 32'(wr), 0);
        chk("queue_drained", 32'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
